// File: rtl/dcache_rd_resp_if.sv
// Load-request, SRAM-port and response signals of the memory-stage read responder.
// The slave modport is the responder's view; master is the surrounding pipeline/SRAM.
interface dcache_rd_resp_if #(
  parameter int MEM_AW = 13
);
  logic              req_valid;
  logic [MEM_AW+1:0] req_pa;
  logic [1:0]        req_size;
  logic              req_spill;
  logic [2:0]        req_frame2;
  logic              req_ready;
  logic              glb_inv;
  logic              mem_req;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              resp_twobeat;

  modport slave (
    input  req_valid, req_pa, req_size, req_spill, req_frame2, glb_inv, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_addr, resp_valid, resp_data, resp_twobeat
  );

  modport master (
    output req_valid, req_pa, req_size, req_spill, req_frame2, glb_inv, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_addr, resp_valid, resp_data, resp_twobeat
  );
endinterface

// File: rtl/dcache_rd_resp.sv
// Memory-stage read responder: one or two SRAM word reads per load, merged into
// right-aligned, zero-extended load data delivered with a one-cycle valid pulse.
module dcache_rd_resp #(
  parameter int MEM_AW = 13
) (
  input  logic             i_clk,
  input  logic             i_rst,
  dcache_rd_resp_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_off, w_off_nxt;
  logic [1:0]        r_size, w_size_nxt;
  logic              r_cross, w_cross_nxt;
  logic [MEM_AW-1:0] r_addr1, w_addr1_nxt;
  logic [MEM_AW-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [31:0]       r_word0, w_word0_nxt;
  logic [31:0]       r_resp_data, w_resp_data_nxt;
  logic              r_mem_req, w_mem_req_nxt;
  logic              r_resp_valid, w_resp_valid_nxt;
  logic              r_resp_twobeat, w_resp_twobeat_nxt;

  logic              w_beat;
  logic              w_req_cross;
  logic [63:0]       w_pair;
  logic [63:0]       w_shift;
  logic [31:0]       w_mask;
  logic [31:0]       w_load;

  always_comb begin
    w_beat      = r_mem_req & bus.mem_ack;
    w_req_cross = ({1'b0, bus.req_pa[1:0]} + {1'b0, bus.req_size}) > 3'd3;

    // Load formatting works on the word arriving this cycle; a single-beat load sees word1 as zero.
    w_pair  = (r_state == RD1) ? {bus.mem_rdata, r_word0} : {32'h0, bus.mem_rdata};
    w_shift = w_pair >> {r_off, 3'b000};
    w_mask  = 32'hFFFF_FFFF >> {~r_size, 3'b000};
    w_load  = w_shift[31:0] & w_mask;

    w_state_nxt        = r_state;
    w_off_nxt          = r_off;
    w_size_nxt         = r_size;
    w_cross_nxt        = r_cross;
    w_addr1_nxt        = r_addr1;
    w_mem_addr_nxt     = r_mem_addr;
    w_word0_nxt        = r_word0;
    w_mem_req_nxt      = r_mem_req;
    w_resp_data_nxt    = r_resp_data;
    w_resp_twobeat_nxt = r_resp_twobeat;
    w_resp_valid_nxt   = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (bus.req_valid && !bus.glb_inv) begin
          w_off_nxt      = bus.req_pa[1:0];
          w_size_nxt     = bus.req_size;
          w_cross_nxt    = w_req_cross;
          w_addr1_nxt    = (bus.req_spill && w_req_cross)
                         ? {bus.req_frame2, {(MEM_AW-3){1'b0}}}
                         : bus.req_pa[MEM_AW+1:2] + MEM_AW'(1);
          w_mem_addr_nxt = bus.req_pa[MEM_AW+1:2];
          w_mem_req_nxt  = 1'b1;
          w_state_nxt    = RD0;
        end
      end
      RD0: begin
        if (bus.glb_inv) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = IDLE;
        end else if (w_beat) begin
          w_word0_nxt = bus.mem_rdata;
          if (r_cross) begin
            w_mem_addr_nxt = r_addr1;
            w_state_nxt    = RD1;
          end else begin
            w_mem_req_nxt      = 1'b0;
            w_resp_valid_nxt   = 1'b1;
            w_resp_data_nxt    = w_load;
            w_resp_twobeat_nxt = 1'b0;
            w_state_nxt        = RESP;
          end
        end
      end
      RD1: begin
        if (bus.glb_inv) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = IDLE;
        end else if (w_beat) begin
          w_mem_req_nxt      = 1'b0;
          w_resp_valid_nxt   = 1'b1;
          w_resp_data_nxt    = w_load;
          w_resp_twobeat_nxt = 1'b1;
          w_state_nxt        = RESP;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state        <= IDLE;
      r_off          <= '0;
      r_size         <= '0;
      r_cross        <= 1'b0;
      r_addr1        <= '0;
      r_mem_addr     <= '0;
      r_word0        <= '0;
      r_mem_req      <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_data    <= '0;
      r_resp_twobeat <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_off          <= w_off_nxt;
      r_size         <= w_size_nxt;
      r_cross        <= w_cross_nxt;
      r_addr1        <= w_addr1_nxt;
      r_mem_addr     <= w_mem_addr_nxt;
      r_word0        <= w_word0_nxt;
      r_mem_req      <= w_mem_req_nxt;
      r_resp_valid   <= w_resp_valid_nxt;
      r_resp_data    <= w_resp_data_nxt;
      r_resp_twobeat <= w_resp_twobeat_nxt;
    end
  end

  // The pulse is already registered when a flush lands in RESP, so the flush masks it on the way out.
  assign bus.resp_valid   = r_resp_valid & ~bus.glb_inv;
  assign bus.req_ready    = (r_state == IDLE);
  assign bus.mem_req      = r_mem_req;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.resp_data    = r_resp_data;
  assign bus.resp_twobeat = r_resp_twobeat;

endmodule

// File: doc/dcache_rd_resp.md
# dcache_rd_resp

Memory-stage read responder: the receiving end of the load request the TLB stage issues (physical address, request size, page-spill flag, request-valid). It accepts one request at a time and performs one or two word reads against the data SRAM port. When an access straddles a word boundary it merges the two words, then returns byte-aligned, zero-extended load data with a one-cycle valid pulse. While busy it backpressures the TLB stage, and it abandons in-flight work on a global invalidate.

## Interface
Parameters:
- MEM_AW, 13: word-address width of the SRAM port (15-bit byte physical address).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  1  TLB stage presents a request.
- req_pa  in  15  byte physical address {frame[2:0], offset[11:0]}.
- req_size  in  2  bytes minus one (0 = 1 B … 3 = 4 B).
- req_spill  in  1  second word lies on a different page.
- req_frame2  in  3  frame of the next page; used only when req_spill = 1.
- req_ready  out  1  high only in IDLE; a request is accepted on an edge with req_valid & req_ready.
- glb_inv  in  1  flush; aborts the current request.
- mem_req  out  1  SRAM read request; held until acked.
- mem_addr  out  MEM_AW  word address; stable while mem_req is high.
- mem_ack  in  1  the beat completes on an edge with mem_req & mem_ack; may be high in the first cycle of mem_req.
- mem_rdata  in  32  read word, valid with mem_ack.
- resp_valid  out  1  one-cycle pulse with the load data.
- resp_data  out  32  right-aligned, little-endian, zero-extended data.
- resp_twobeat  out  1  the response needed two SRAM reads; qualified by resp_valid.

## Operation
- States: IDLE, RD0, RD1, RESP. All outputs are registered; state is held in flops clocked by clk.
- Reset (rst = 0 at an edge): state goes to IDLE, and mem_req = 0, mem_addr = 0, resp_valid = 0, resp_data = 0, resp_twobeat = 0. req_ready = 1 from the first cycle after reset.
- Acceptance in IDLE latches the request fields:
  - off = pa[1:0].
  - cross = (off + size) > 3, computed in 3-bit arithmetic.
  - addr0 = pa[14:2].
  - addr1 = {frame2, 10'h000} if spill, otherwise pa[14:2] + 1, truncated to MEM_AW bits (wraps 0x1FFF → 0x0000).
  - If req_spill = 1 but cross = 0, the spill flag is ignored and one beat is performed.
- Next state after acceptance is RD0, with mem_req = 1 and mem_addr = addr0.
- RD0, on a beat: capture word0. If cross, go to RD1 with mem_addr = addr1 and mem_req kept high; otherwise go to RESP with mem_req = 0.
- RD1, on a beat: capture word1, go to RESP, mem_req = 0.
- Without mem_ack, RD0 and RD1 hold state, mem_req and mem_addr.
- RESP drives resp_valid = 1 for exactly one cycle, then returns to IDLE.
  - resp_data = ({word1, word0} >> (8 × off))[31:0], masked to (size + 1) bytes.
  - For a single-beat response, word1 is treated as 0.
  - resp_twobeat = cross.
- glb_inv:
  - In RD0 or RD1: at that edge go to IDLE, drop mem_req, and produce no resp_valid. An ack in the same cycle is discarded.
  - In RESP: suppresses resp_valid, and the state goes to IDLE.
  - In IDLE: blocks acceptance that cycle.
- req_valid outside IDLE is ignored; the TLB stage holds its request until accepted.

## Timing
- Zero-wait SRAM (mem_ack high whenever mem_req is high), acceptance at edge E:
  - single beat: mem_req high in cycle E+1, resp_valid in cycle E+2.
  - two beats: mem_req high in E+1 and E+2, resp_valid in E+3.
- Each wait cycle on mem_ack adds one cycle of latency.
- req_ready is low from cycle E+1 until the cycle after the resp_valid pulse.
- Peak throughput is one single-beat load every 3 cycles.
- Simultaneous events:
  - rst = 0 overrides everything, including glb_inv and mem_ack.
  - glb_inv overrides mem_ack.

## Test plan
- Aligned word load: pa = 0x1234, size = 3, SRAM word 0x048D = 0xDEADBEEF, zero-wait → mem_addr = 0x048D in E+1; resp_data = 0xDEADBEEF and resp_twobeat = 0 in E+2; req_ready back high in E+3.
- Unaligned byte and halfword loads, word 0x0100 = 0x44332211:
  - pa = 0x0402, size = 0 → 0x00000033.
  - pa = 0x0401, size = 1 → 0x00003322.
- In-page word crossing: pa = 0x0006, size = 3, word 1 = 0xAABBCCDD, word 2 = 0x11223344, mem_ack delayed 2 cycles per beat → mem_addr = 0x001 then 0x002; resp_data = 0x3344AABB; resp_twobeat = 1; resp_valid 7 cycles after acceptance.
- Page spill: pa = 0x1FFE, size = 3, spill = 1, frame2 = 5, word 0x07FF = 0x12345678, word 0x1400 = 0x9ABCDEF0 → second mem_addr = 0x1400; resp_data = 0xDEF01234. Repeat with spill = 0 → second address 0x0800. Repeat with pa = 0x7FFE, spill = 0 → second address wraps to 0x0000.
- Flush: glb_inv asserted in RD1 while mem_ack = 1 → no resp_valid, mem_req low next cycle, req_ready high next cycle. A following request completes normally.
- Reset mid-operation: rst = 0 during a stalled RD0 → next cycle mem_req = 0, resp_valid = 0, resp_data = 0, req_ready = 1. A req_valid held through reset is not accepted until rst = 1.
